// File: rtl/lvds_dual_pattern_gen.sv
// lvds_dual_pattern_gen: dual-channel (odd/even pixel) video timing and
// test-pattern source for the LVDS transmit path. One pixel pair per clock,
// all outputs registered with one clock of latency from the counter state.
// Optional feature: define LVDS_PG_GRID_EN to compile in the grid pattern;
// without it, pattern select 2 falls back to colour bars.
module lvds_dual_pattern_gen #(
    parameter int H_ACTIVE = 960,
    parameter int H_FP     = 44,
    parameter int H_SYNC   = 22,
    parameter int H_BP     = 74,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        I_clk_1x,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic [1:0]  I_pattern,
    input  logic [23:0] I_solid_rgb,
    output logic [7:0]  O_R_data_o,
    output logic [7:0]  O_G_data_o,
    output logic [7:0]  O_B_data_o,
    output logic [7:0]  O_R_data_e,
    output logic [7:0]  O_G_data_e,
    output logic [7:0]  O_B_data_e,
    output logic        O_DE,
    output logic        O_HS,
    output logic        O_VS,
    output logic        O_frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_L   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_L   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_L = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_L   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_L   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_L = VW'(V_TOT - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q, pat_d;
    logic [23:0]   solid_q, solid_d;
    logic [23:0]   rgb_o_q, rgb_o_d;
    logic [23:0]   rgb_e_q, rgb_e_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;

    logic          first_pair, h_act, v_act;
    logic [HW:0]   x_full;
    logic [7:0]    x_o, x_e;
    logic [23:0]   pix_o, pix_e;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    endfunction

    // Raster counters, bar tracker and pattern latch next-state.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        bar_pix_d  = bar_pix_q;
        bar_idx_d  = bar_idx_q;
        pat_d      = pat_q;
        solid_d    = solid_q;
        first_pair = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_act      = (h_cnt_q < H_ACT_L);
        v_act      = (v_cnt_q < V_ACT_L);

        if (!I_en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST_L) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_L) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        // Bar position follows h_cnt by counting pairs instead of dividing.
        if (!I_en || h_cnt_q == H_LAST_L) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (h_act) begin
            if (bar_pix_q == BAR_LAST) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
        end

        // The pair at (0,0) already uses the freshly sampled selection.
        if (I_en && first_pair) begin
            pat_d   = I_pattern;
            solid_d = I_solid_rgb;
        end
    end

    // Pixel generation and output next-state.
    always_comb begin
        x_full = {h_cnt_q, 1'b0};
        x_o    = 8'(x_full);
        x_e    = x_o | 8'd1;
        pix_o  = bar_rgb(bar_idx_q);
        pix_e  = bar_rgb(bar_idx_q);
        case (pat_d)
            2'd1: begin
                pix_o = {x_o, x_o, x_o};
                pix_e = {x_e, x_e, x_e};
            end
`ifdef LVDS_PG_GRID_EN
            2'd2: begin
                pix_e = (5'(v_cnt_q) == 5'd0) ? 24'hFFFFFF : 24'h000000;
                pix_o = ((x_o[4:0] == 5'd0) || (5'(v_cnt_q) == 5'd0)) ? 24'hFFFFFF : 24'h000000;
            end
`endif
            2'd3: begin
                pix_o = solid_d;
                pix_e = solid_d;
            end
            default: ;
        endcase

        de_d    = I_en && h_act && v_act;
        rgb_o_d = de_d ? pix_o : 24'h0;
        rgb_e_d = de_d ? pix_e : 24'h0;
        hs_d    = (I_en && h_cnt_q >= H_SS_L && h_cnt_q < H_SE_L) ? SYNC_POL : ~SYNC_POL;
        vs_d    = (I_en && v_cnt_q >= V_SS_L && v_cnt_q < V_SE_L) ? SYNC_POL : ~SYNC_POL;
        fs_d    = I_en && first_pair;
    end

    // State and output registers.
    always_ff @(posedge I_clk_1x or posedge I_rst) begin
        if (I_rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            rgb_o_q   <= '0;
            rgb_e_q   <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            rgb_o_q   <= rgb_o_d;
            rgb_e_q   <= rgb_e_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
        end
    end

    assign O_R_data_o    = rgb_o_q[23:16];
    assign O_G_data_o    = rgb_o_q[15:8];
    assign O_B_data_o    = rgb_o_q[7:0];
    assign O_R_data_e    = rgb_e_q[23:16];
    assign O_G_data_e    = rgb_e_q[15:8];
    assign O_B_data_e    = rgb_e_q[7:0];
    assign O_DE          = de_q;
    assign O_HS          = hs_q;
    assign O_VS          = vs_q;
    assign O_frame_start = fs_q;

endmodule

// File: tb/tb_lvds_dual_pattern_gen.sv
// Directed bench for lvds_dual_pattern_gen using a small 24x8 raster.
module tb_lvds_dual_pattern_gen;

    localparam int HA = 16, HF = 2, HSY = 2, HB = 4;
    localparam int VA = 4, VF = 1, VSY = 1, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  pattern;
    logic [23:0] solid;
    logic [7:0]  r_o, g_o, b_o, r_e, g_e, b_e;
    logic        de, hs, vs, fs;

    int checks = 0;
    int errors = 0;
    int mh, mv;
    logic [1:0]  mpat;
    logic [23:0] msolid;
    logic [23:0] bars [8];

    lvds_dual_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut (
        .I_clk_1x(clk), .I_rst(rst), .I_en(en),
        .I_pattern(pattern), .I_solid_rgb(solid),
        .O_R_data_o(r_o), .O_G_data_o(g_o), .O_B_data_o(b_o),
        .O_R_data_e(r_e), .O_G_data_e(g_e), .O_B_data_e(b_e),
        .O_DE(de), .O_HS(hs), .O_VS(vs), .O_frame_start(fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask

    task automatic check_blank(input string tag);
        chk({tag, "_de"}, {31'd0, de}, 32'd0);
        chk({tag, "_hs"}, {31'd0, hs}, 32'd0);
        chk({tag, "_vs"}, {31'd0, vs}, 32'd0);
        chk({tag, "_fs"}, {31'd0, fs}, 32'd0);
        chk({tag, "_rgb_o"}, {8'd0, r_o, g_o, b_o}, 32'd0);
        chk({tag, "_rgb_e"}, {8'd0, r_e, g_e, b_e}, 32'd0);
    endtask

    function automatic logic [23:0] exp_pix(input int h, input int v, input bit even);
        int x;
        logic [7:0] xb;
        x  = 2 * h + (even ? 1 : 0);
        xb = 8'(x);
        case (mpat)
            2'd1: return {xb, xb, xb};
`ifdef LVDS_PG_GRID_EN
            2'd2: begin
                if (v % 32 == 0) return 24'hFFFFFF;
                if (!even && (x % 32 == 0)) return 24'hFFFFFF;
                return 24'h000000;
            end
`endif
            2'd3: return msolid;
            default: return bars[h / (HA / 8)];
        endcase
    endfunction

    task automatic step();
        logic e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_po, e_pe;
        e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_po = 0; e_pe = 0;
        if (en) begin
            if (mh == 0 && mv == 0) begin
                mpat   = pattern;
                msolid = solid;
            end
            e_de = (mh < HA) && (mv < VA);
            e_hs = (mh >= HA + HF) && (mh < HA + HF + HSY);
            e_vs = (mv >= VA + VF) && (mv < VA + VF + VSY);
            e_fs = (mh == 0) && (mv == 0);
            if (e_de) begin
                e_po = exp_pix(mh, mv, 1'b0);
                e_pe = exp_pix(mh, mv, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        chk("de", {31'd0, de}, {31'd0, e_de});
        chk("hs", {31'd0, hs}, {31'd0, e_hs});
        chk("vs", {31'd0, vs}, {31'd0, e_vs});
        chk("frame_start", {31'd0, fs}, {31'd0, e_fs});
        chk("rgb_odd", {8'd0, r_o, g_o, b_o}, {8'd0, e_po});
        chk("rgb_even", {8'd0, r_e, g_e, b_e}, {8'd0, e_pe});
        if (en) begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst = 1'b1; en = 1'b0; pattern = 2'd0; solid = 24'h0;
        mh = 0; mv = 0; mpat = 2'd0; msolid = 24'h0;

        #3;
        check_blank("reset");
        en = 1'b1;
        @(posedge clk);
        #1;
        check_blank("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Frame 1: colour bars, full timing check.
        run(HT * VT);
        // Frame 2: gradient.
        pattern = 2'd1;
        run(HT * VT);
        // Solid latched at frame start, select changed mid-frame.
        pattern = 2'd3;
        solid   = 24'h123456;
        run(60);
        pattern = 2'd0;
        solid   = 24'hABCDEF;
        run(HT * VT);
        // Pattern 2 for a frame.
        pattern = 2'd2;
        run(HT * VT + 2);
        // Enable dropped mid-line.
        en = 1'b0;
        run(30);
        en = 1'b1;
        pattern = 2'd1;
        run(200);
        // Asynchronous reset mid-frame.
        rst = 1'b1;
        #1;
        check_blank("rst_async");
        mh = 0; mv = 0; mpat = 2'd0; msolid = 24'h0;
        pattern = 2'd3;
        solid   = 24'h00FF80;
        @(negedge clk);
        rst = 1'b0;
        run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
